// File: rtl/serial_word_tx_pkg.sv
// Shared definitions for the serial word transmitter and the detector benches.
package serial_word_tx_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } tx_state_t;

endpackage

// File: rtl/serial_word_tx_piso_shift_reg.sv
// Parallel-in serial-out register that holds the word and its shift direction.
module piso_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic             shift_en,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    output logic             q_out
);

    logic [WIDTH-1:0] shreg;
    logic             dir_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            dir_q <= 1'b0;
        end else if (ld) begin
            shreg <= d;
            dir_q <= dir;
        end else if (shift_en) begin
            // Always shift toward the end that q_out reads from.
            if (dir_q) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        q_out = dir_q ? shreg[WIDTH-1] : shreg[0];
    end

endmodule

// File: rtl/serial_word_tx.sv
// Loads a parallel word on a load/ready handshake and shifts it out on w, one bit per clock.
module serial_word_tx
    import serial_word_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             msb_first,
    output logic             ready,
    output logic             w,
    output logic             w_valid,
    output logic             done
);

    tx_state_t        state;
    tx_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic             ld;
    logic             shift_en;
    logic             q_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Encoding 2'b11 lands in the default arm and recovers to IDLE.
    always_comb begin
        state_next = IDLE;
        ld         = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    ld         = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                shift_en   = 1'b1;
                state_next = (cnt == '0) ? DONE : SHIFT;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= CNT_W'(WIDTH - 1);
        end else if (state == SHIFT && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    piso_shift_reg #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .ld       (ld),
        .shift_en (shift_en),
        .dir      (msb_first),
        .d        (din),
        .q_out    (q_out)
    );

    always_comb begin
        ready   = (state == IDLE);
        w_valid = (state == SHIFT);
        done    = (state == DONE);
        w       = (state == SHIFT) && q_out;
    end

endmodule
